intt_result_reader: RTL and testbench

- Read-side counterpart of the INTT load path: after the INTT core asserts its done flag, this block reads the result polynomial out of the core's data BRAM and streams it to the host/ACAP side.
- Output uses a valid/ready handshake with back-pressure.
- Applies a final conditional subtraction of q so that lazily reduced coefficients in [0,2q) leave the block in [0,q).
- Sits between the INTT core's bramOut port and the external data_out bus.

---
 rtl/intt_result_reader.sv | 187 ++++++++++++++++++
 tb/tb_intt_result_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_result_reader.sv
// -----------------------------------------------------------------------------
// intt_result_reader
//
// Unloads one result polynomial from the INTT core's data BRAM and streams it
// out as beats of 2*PE_NUMBER coefficients over a valid/ready interface. Each
// coefficient gets one conditional subtraction of q, so lazily reduced values
// in [0,2q) leave the block in [0,q).
//
// Reads are issued only while there is guaranteed room in the output FIFO for
// every outstanding read (FIFO occupancy + reads still in the BRAM pipeline).
// This lets the BRAM run freely with no stall input while the sink applies
// arbitrary back-pressure.
//
// Ports:
//   clk         clock
//   reset       asynchronous active-high reset
//   start_read  one-cycle pulse, begin unloading (ignored unless idle)
//   modulus     q, captured on an accepted start_read
//   bram_ren    BRAM read enable
//   bram_raddr  BRAM beat address
//   bram_rdata  BRAM read data, valid BRAM_LAT cycles after bram_ren
//   m_data      reduced output beat (zero when m_valid is low)
//   m_valid     m_data holds a beat
//   m_ready     sink accepts the beat when m_valid && m_ready
//   m_last      final beat of the polynomial
//   busy        transfer in progress
//   done_read   one-cycle pulse once the last beat has been accepted
// -----------------------------------------------------------------------------
module intt_result_reader #(
  parameter int DATA_SIZE_ARB = 32,
  parameter int RING_DEPTH    = 10,
  parameter int PE_DEPTH      = 3,
  parameter int BRAM_LAT      = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start_read,
  input  logic [DATA_SIZE_ARB-1:0]                  modulus,
  output logic                                      bram_ren,
  output logic [RING_DEPTH-PE_DEPTH-2:0]            bram_raddr,
  input  logic [DATA_SIZE_ARB*2*(1<<PE_DEPTH)-1:0]  bram_rdata,
  output logic [DATA_SIZE_ARB*2*(1<<PE_DEPTH)-1:0]  m_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic                                      m_last,
  output logic                                      busy,
  output logic                                      done_read
);

  localparam int PE_NUMBER = 1 << PE_DEPTH;
  localparam int LANES     = 2 * PE_NUMBER;
  localparam int BEAT_W    = DATA_SIZE_ARB * LANES;
  localparam int ADDR_W    = RING_DEPTH - PE_DEPTH - 1;
  localparam int NBEATS    = 1 << ADDR_W;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CRD_W     = $clog2(FIFO_DEPTH + BRAM_LAT + 1) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]               r_state;
  logic [DATA_SIZE_ARB-1:0] r_q;
  logic [CNT_W-1:0]         r_rd_cnt;
  logic [CNT_W-1:0]         r_out_cnt;
  logic [BRAM_LAT-1:0]      r_vsr;
  logic [BEAT_W-1:0]        r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CRD_W-1:0]         r_fifo_cnt;

  logic [CRD_W-1:0]         w_inflight;
  logic                     w_credit_ok;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_done;
  logic [BEAT_W-1:0]        w_reduced;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads still travelling through the BRAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < BRAM_LAT; i++) begin
      w_inflight = w_inflight + CRD_W'(r_vsr[i]);
    end
  end

  // A read may only be issued if its data is sure to find a FIFO slot,
  // counting every read that has not yet been popped.
  assign w_credit_ok = (r_fifo_cnt + w_inflight) < CRD_W'(FIFO_DEPTH);
  assign w_issue     = (r_state == S_READ) && (r_rd_cnt < CNT_W'(NBEATS)) && w_credit_ok;
  assign bram_ren    = w_issue;
  assign bram_raddr  = r_rd_cnt[ADDR_W-1:0];

  assign w_push  = r_vsr[BRAM_LAT-1];
  assign m_valid = (r_fifo_cnt != '0);
  assign w_pop   = m_valid && m_ready;
  assign m_data  = m_valid ? r_fifo_mem[r_rd_ptr] : '0;
  assign m_last  = m_valid && (r_out_cnt == CNT_W'(NBEATS - 1));

  assign w_done    = (r_state == S_DRAIN) && (r_out_cnt == CNT_W'(NBEATS));
  assign done_read = w_done;
  assign busy      = (r_state != S_IDLE) && !w_done;

  // Final lazy-reduction step, one comparator/subtractor per lane.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_SIZE_ARB-1:0] w_lane;
      assign w_lane = bram_rdata[gi*DATA_SIZE_ARB +: DATA_SIZE_ARB];
      assign w_reduced[gi*DATA_SIZE_ARB +: DATA_SIZE_ARB] =
        (w_lane >= r_q) ? (w_lane - r_q) : w_lane;
    end
  endgenerate

  // Control FSM and beat counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_rd_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_issue) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (w_pop)   r_out_cnt <= r_out_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (start_read) begin
            r_q       <= modulus;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          if (w_issue && (r_rd_cnt == CNT_W'(NBEATS - 1))) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid tag travelling alongside each read; clearing it on reset drops
  // any BRAM returns that were already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsr <= '0;
    end else begin
      r_vsr[0] <= w_issue;
      for (int i = 1; i < BRAM_LAT; i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end
    end
  end

  // FIFO storage: writing the reduced lanes here is the output register
  // stage of the return path.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_reduced;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CRD_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CRD_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_intt_result_reader.sv
// -----------------------------------------------------------------------------
// Testbench for intt_result_reader: BRAM model with fixed 2-cycle latency,
// expected beats built from the modular-reduction rule, per-cycle checks of
// addresses, read credit, output ordering and stall stability.
// -----------------------------------------------------------------------------
module tb_intt_result_reader;

  localparam int W      = 32;
  localparam int LANES  = 16;
  localparam int BEAT_W = W * LANES;
  localparam int NBEATS = 64;
  localparam int FIFO_D = 4;
  localparam logic [W-1:0] Q0 = 32'h3FFF_FFC1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_read = 1'b0;
  logic [W-1:0]      modulus = '0;
  logic              bram_ren;
  logic [5:0]        bram_raddr;
  logic [BEAT_W-1:0] bram_rdata = '0;
  logic [BEAT_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              busy;
  logic              done_read;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BEAT_W-1:0] mem     [NBEATS];
  logic [BEAT_W-1:0] exp_beat[NBEATS];
  logic [BEAT_W-1:0] rd_p1 = '0;
  logic [BEAT_W-1:0] junk  = '0;

  always #5 clk = ~clk;

  intt_result_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start_read (start_read),
    .modulus    (modulus),
    .bram_ren   (bram_ren),
    .bram_raddr (bram_raddr),
    .bram_rdata (bram_rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done_read  (done_read)
  );

  // BRAM: data appears two cycles after the enable; garbage otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) junk[i*W +: W] <= $urandom;
    rd_p1      <= bram_ren ? mem[bram_raddr] : junk;
    bram_rdata <= rd_p1;
  end

  task automatic check_val(input string tag, input logic [BEAT_W-1:0] got,
                           input logic [BEAT_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: lanes = beat index; mode 1: q-1,q,q+5,2q-1 pattern; mode 2: random in [0,2q)
  task automatic load_mem(input int mode, input logic [W-1:0] q);
    logic [W-1:0]  v;
    logic [W-1:0]  e;
    logic [63:0]   t;
    for (int k = 0; k < NBEATS; k++) begin
      for (int l = 0; l < LANES; l++) begin
        case (mode)
          0:       v = W'(k);
          1: begin
            case (l % 4)
              0:       begin v = q - 1;      e = q - 1; end
              1:       begin v = q;          e = '0;    end
              2:       begin v = q + 5;      e = 32'd5; end
              default: begin v = 2 * q - 1;  e = q - 1; end
            endcase
          end
          default: v = $urandom_range(2 * q - 1, 0);
        endcase
        if (mode != 1) begin
          t = {32'b0, v} % {32'b0, q};
          e = t[W-1:0];
        end
        mem[k][l*W +: W]      = v;
        exp_beat[k][l*W +: W] = e;
      end
    end
  endtask

  function automatic logic ready_for(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (cyc >= 30 && cyc < 50) return 1'b0;
    return logic'($urandom % 2);
  endfunction

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; start_read = 1'b0;
      @(negedge clk);
      check_val({tag, "_valid"}, m_valid, 1'b0);
      check_val({tag, "_ren"}, bram_ren, 1'b0);
      check_val({tag, "_busy"}, busy, 1'b0);
      check_val({tag, "_done"}, done_read, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, m_valid, 1'b0);
    check_val({tag, "_data"}, m_data, '0);
    check_val({tag, "_last"}, m_last, 1'b0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done"}, done_read, 1'b0);
    check_val({tag, "_ren"}, bram_ren, 1'b0);
    check_val({tag, "_raddr"}, bram_raddr, '0);
  endtask

  task automatic run_xfer(input logic [W-1:0] q, input int rmode, input int extra_start,
                          input int abort_at, input bit chk_timing, input int idle_after);
    int cyc, issued, acc, done_cnt, first_valid, done_cyc;
    bit stall_prev, last_prev, fin;
    logic [BEAT_W-1:0] data_prev;
    cyc = 0; issued = 0; acc = 0; done_cnt = 0; first_valid = -1; done_cyc = -1;
    stall_prev = 1'b0; last_prev = 1'b0; fin = 1'b0; data_prev = '0;
    @(posedge clk); #1;
    start_read = 1'b1;
    modulus    = q;
    m_ready    = ready_for(rmode, 0);
    while (!fin) begin
      @(negedge clk);
      if (chk_timing && cyc == 0) check_val("busy_in_start_cycle", busy, 1'b0);
      if (chk_timing && cyc == 1) check_val("busy_after_start", busy, 1'b1);
      if (bram_ren) begin
        check_val("raddr", bram_raddr, issued);
        issued++;
      end
      check_val("credit_limit", (issued - acc) <= FIFO_D, 1'b1);
      if (stall_prev) begin
        check_val("stall_valid", m_valid, 1'b1);
        check_val("stall_data", m_data, data_prev);
        check_val("stall_last", m_last, last_prev);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        if (acc < NBEATS) begin
          check_val($sformatf("beat%0d_data", acc), m_data, exp_beat[acc]);
          check_val($sformatf("beat%0d_last", acc), m_last, acc == NBEATS - 1);
        end else begin
          check_val("extra_beat", acc, NBEATS - 1);
        end
        acc++;
      end
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      last_prev  = m_last;
      if (done_read) begin
        done_cnt++;
        done_cyc = cyc;
        check_val("busy_at_done", busy, 1'b0);
        check_val("beats_before_done", acc, NBEATS);
        fin = 1'b1;
      end
      if (abort_at >= 0 && acc == abort_at) fin = 1'b1;
      if (cyc >= 3000) begin
        check_val("timeout", 1'b0, 1'b1);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
        start_read = (cyc == extra_start);
        modulus    = $urandom;
        m_ready    = ready_for(rmode, cyc);
      end
    end
    if (abort_at < 0) begin
      check_val("beats_total", acc, NBEATS);
      check_val("reads_total", issued, NBEATS);
      check_val("done_pulses", done_cnt, 1);
      if (chk_timing) begin
        check_val("first_valid_latency", first_valid, 4);
        check_val("done_cycle", done_cyc, NBEATS + 4);
      end
      $display("[TB] transfer q=%h beats=%0d reads=%0d done_cycle=%0d", q, acc, issued, done_cyc);
      if (idle_after > 0) check_idle(idle_after, "post_done");
    end else begin
      // Abort with reads still in the BRAM pipeline; release reset mid-cycle
      // so the stale BRAM returns arrive while the block is running again.
      @(posedge clk); #1;
      reset = 1'b1;
      start_read = 1'b0;
      #1;
      check_all_zero("abort");
      @(negedge clk);
      reset = 1'b0;
      check_idle(8, "after_abort");
      $display("[TB] aborted transfer after %0d beats, reads=%0d", acc, issued);
    end
  endtask

  initial begin
    logic [W-1:0] q;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    check_idle(2, "idle_after_reset");

    // Ramp data, full rate, exact timing.
    load_mem(0, Q0);
    run_xfer(Q0, 0, -1, -1, 1'b1, 3);

    // Reduction boundary values.
    load_mem(1, Q0);
    run_xfer(Q0, 0, -1, -1, 1'b1, 3);

    // Random data, random back-pressure with a long stall burst.
    q = $urandom_range(32'h7FFF_FFFF, 2);
    load_mem(2, q);
    run_xfer(q, 1, -1, -1, 1'b0, 3);

    // Extra start_read while reading, with a different modulus on the bus.
    q = $urandom_range(32'h7FFF_FFFF, 2);
    load_mem(2, q);
    run_xfer(q, 0, 10, -1, 1'b0, 3);

    // Abort at beat 30, then a clean transfer.
    load_mem(0, Q0);
    run_xfer(Q0, 0, -1, 30, 1'b0, 0);
    q = $urandom_range(32'h7FFF_FFFF, 2);
    load_mem(2, q);
    run_xfer(q, 0, -1, -1, 1'b1, 3);

    // Back-to-back: second start in the cycle after done_read.
    q = $urandom_range(32'h7FFF_FFFF, 2);
    load_mem(2, q);
    run_xfer(q, 1, -1, -1, 1'b0, 0);
    q = $urandom_range(32'h7FFF_FFFF, 2);
    load_mem(2, q);
    run_xfer(q, 0, -1, -1, 1'b1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
